charge_pump_monitor: RTL and testbench

- Receive-side decoder for the charge-pump control interface (preChrg, snk, src_n), in the same clock domain as the pump controller.
- Detects source and sink pulses and groups them into bursts; reports burst length and direction.
- Maintains a signed net-charge estimate and flags protocol violations.
- Feeds the loop-control/observability logic that checks the pump sequence at run time.

---
 rtl/charge_pump_monitor.sv | 248 ++++++++++++++++++++++++
 tb/tb_charge_pump_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/charge_pump_monitor.sv
// ============================================================================
//  Module   : charge_pump_monitor
//  Purpose  : Receive-side decoder for the charge-pump control interface
//             (preChrg, snk, src_n). Detects sink/source pulses, groups
//             them into bursts, keeps a saturating signed net-charge
//             estimate and raises sticky protocol-violation flags.
//  Options  : CP_MON_STATS_EN - adds per-direction burst counters
//             (sink_bursts, src_bursts).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module charge_pump_monitor #(
    parameter int CNT_W     = 8,
    parameter int BURST_W   = 6,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    preChrg_i,
    input  logic                    snk_i,
    input  logic                    src_n_i,
    input  logic                    clear_err,
    output logic [1:0]              phase,
    output logic signed [CNT_W-1:0] net_charge,
    output logic                    burst_valid,
    output logic [BURST_W-1:0]      burst_len,
    output logic                    burst_dir,
    output logic                    err_overlap,
    output logic                    err_precharge,
    output logic                    err_long
`ifdef CP_MON_STATS_EN
    ,
    output logic [15:0]             sink_bursts,
    output logic [15:0]             src_bursts
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [BURST_W-1:0]      RUN_MAX     = '1;
    localparam logic [BURST_W-1:0]      RUN_ONE     = BURST_W'(1);
    localparam logic [BURST_W-1:0]      MAX_BURST_V = BURST_W'(MAX_BURST);
    localparam logic [TMR_W-1:0]        TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]        TMR_ONE     = TMR_W'(1);
    localparam logic signed [CNT_W-1:0] NET_MAX     = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] NET_MIN     = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] NET_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_PRECHG = 2'd1,
        PH_SINK   = 2'd2,
        PH_SOURCE = 2'd3
    } phase_t;

    // Previous-value registers for edge detection
    logic                    snk_q, src_n_q, preChrg_q;

    // Monitor state and registered outputs
    phase_t                  phase_q, phase_d;
    logic [BURST_W-1:0]      run_q, run_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic signed [CNT_W-1:0] net_q, net_d;
    logic                    bvalid_q, bvalid_d;
    logic [BURST_W-1:0]      blen_q, blen_d;
    logic                    bdir_q, bdir_d;
    logic                    eovl_q, eovl_d;
    logic                    epre_q, epre_d;
    logic                    elong_q, elong_d;

    // Combinational helpers
    logic                    sink_p, src_p;
    logic                    net_up, net_dn;
    logic                    set_ovl, set_pre, set_long;
    logic [BURST_W-1:0]      run_inc;

    assign sink_p  = snk_i & ~snk_q;
    assign src_p   = ~src_n_i & src_n_q;
    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

    // Next-state decode: precharge pre-empts everything, then overlap,
    // then per-phase pulse handling and idle timeout
    always_comb begin
        phase_d  = phase_q;
        run_d    = run_q;
        timer_d  = timer_q;
        net_d    = net_q;
        bvalid_d = 1'b0;
        blen_d   = blen_q;
        bdir_d   = bdir_q;
        net_up   = 1'b0;
        net_dn   = 1'b0;
        set_ovl  = 1'b0;
        set_pre  = 1'b0;
        set_long = 1'b0;

        if (preChrg_i) begin
            // An open burst is closed and reported on precharge entry
            if (phase_q == PH_SINK || phase_q == PH_SOURCE) begin
                bvalid_d = 1'b1;
                blen_d   = run_q;
                bdir_d   = (phase_q == PH_SOURCE);
            end
            phase_d = PH_PRECHG;
            run_d   = '0;
            timer_d = '0;
            set_pre = sink_p | src_p;
            // preChrg_q is high exactly when the monitor sits in PRECHG
            if (!preChrg_q) begin
                net_d = '0;
            end
        end else if (phase_q == PH_PRECHG) begin
            phase_d = PH_IDLE;
            set_pre = sink_p | src_p;
        end else if (sink_p && src_p) begin
            // Ambiguous cycle: flag it and leave the burst untouched
            set_ovl = 1'b1;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (sink_p) begin
                        phase_d = PH_SINK;
                        run_d   = RUN_ONE;
                        timer_d = '0;
                        net_dn  = 1'b1;
                    end else if (src_p) begin
                        phase_d = PH_SOURCE;
                        run_d   = RUN_ONE;
                        timer_d = '0;
                        net_up  = 1'b1;
                    end
                end
                PH_SINK, PH_SOURCE: begin
                    if ((phase_q == PH_SINK && sink_p) ||
                        (phase_q == PH_SOURCE && src_p)) begin
                        // Same direction: extend the burst
                        run_d    = run_inc;
                        timer_d  = '0;
                        set_long = (run_q == MAX_BURST_V) && (run_q != RUN_MAX);
                        net_up   = src_p;
                        net_dn   = sink_p;
                    end else if (sink_p || src_p) begin
                        // Direction change: report old burst, open new one
                        bvalid_d = 1'b1;
                        blen_d   = run_q;
                        bdir_d   = (phase_q == PH_SOURCE);
                        phase_d  = src_p ? PH_SOURCE : PH_SINK;
                        run_d    = RUN_ONE;
                        timer_d  = '0;
                        net_up   = src_p;
                        net_dn   = sink_p;
                    end else if (timer_q == TMR_LAST) begin
                        // Quiet for TIMEOUT cycles: close the burst
                        bvalid_d = 1'b1;
                        blen_d   = run_q;
                        bdir_d   = (phase_q == PH_SOURCE);
                        phase_d  = PH_IDLE;
                        run_d    = '0;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                default: ;
            endcase
        end

        // Saturating net-charge update
        if (net_up && net_q != NET_MAX) begin
            net_d = net_q + NET_ONE;
        end else if (net_dn && net_q != NET_MIN) begin
            net_d = net_q - NET_ONE;
        end

        // Sticky flags: a new error in the clearing cycle survives
        eovl_d  = set_ovl  | (eovl_q  & ~clear_err);
        epre_d  = set_pre  | (epre_q  & ~clear_err);
        elong_d = set_long | (elong_q & ~clear_err);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            snk_q     <= 1'b0;
            src_n_q   <= 1'b0;
            preChrg_q <= 1'b0;
            phase_q   <= PH_IDLE;
            run_q     <= '0;
            timer_q   <= '0;
            net_q     <= '0;
            bvalid_q  <= 1'b0;
            blen_q    <= '0;
            bdir_q    <= 1'b0;
            eovl_q    <= 1'b0;
            epre_q    <= 1'b0;
            elong_q   <= 1'b0;
        end else begin
            snk_q     <= snk_i;
            src_n_q   <= src_n_i;
            preChrg_q <= preChrg_i;
            phase_q   <= phase_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            net_q     <= net_d;
            bvalid_q  <= bvalid_d;
            blen_q    <= blen_d;
            bdir_q    <= bdir_d;
            eovl_q    <= eovl_d;
            epre_q    <= epre_d;
            elong_q   <= elong_d;
        end
    end

    assign phase         = phase_q;
    assign net_charge    = net_q;
    assign burst_valid   = bvalid_q;
    assign burst_len     = blen_q;
    assign burst_dir     = bdir_q;
    assign err_overlap   = eovl_q;
    assign err_precharge = epre_q;
    assign err_long      = elong_q;

`ifdef CP_MON_STATS_EN
    logic [15:0] sink_cnt_q, src_cnt_q;

    // Per-direction burst counters, saturating, cleared with the error flags
    always_ff @(posedge clk) begin
        if (reset || clear_err) begin
            sink_cnt_q <= '0;
            src_cnt_q  <= '0;
        end else if (bvalid_d) begin
            if (bdir_d && src_cnt_q != 16'hFFFF) begin
                src_cnt_q <= src_cnt_q + 16'd1;
            end else if (!bdir_d && sink_cnt_q != 16'hFFFF) begin
                sink_cnt_q <= sink_cnt_q + 16'd1;
            end
        end
    end

    assign sink_bursts = sink_cnt_q;
    assign src_bursts  = src_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_charge_pump_monitor.sv
// ============================================================================
//  Module   : tb_charge_pump_monitor
//  Purpose  : Directed self-checking bench for charge_pump_monitor with a
//             burst-level reference model compared on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_charge_pump_monitor;

    localparam int CNT_W     = 8;
    localparam int BURST_W   = 6;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 32;
    localparam int NET_HI    = (1 << (CNT_W - 1)) - 1;
    localparam int NET_LO    = -(1 << (CNT_W - 1));
    localparam int RUN_HI    = (1 << BURST_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic preChrg_i = 1'b0;
    logic snk_i = 1'b0;
    logic src_n_i = 1'b1;
    logic clear_err = 1'b0;

    logic [1:0]              phase;
    logic signed [CNT_W-1:0] net_charge;
    logic                    burst_valid;
    logic [BURST_W-1:0]      burst_len;
    logic                    burst_dir;
    logic                    err_overlap, err_precharge, err_long;
`ifdef CP_MON_STATS_EN
    logic [15:0]             sink_bursts, src_bursts;
`endif

    charge_pump_monitor #(
        .CNT_W(CNT_W), .BURST_W(BURST_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .preChrg_i(preChrg_i), .snk_i(snk_i),
        .src_n_i(src_n_i), .clear_err(clear_err), .phase(phase),
        .net_charge(net_charge), .burst_valid(burst_valid), .burst_len(burst_len),
        .burst_dir(burst_dir), .err_overlap(err_overlap),
        .err_precharge(err_precharge), .err_long(err_long)
`ifdef CP_MON_STATS_EN
        , .sink_bursts(sink_bursts), .src_bursts(src_bursts)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: burst-level view (phase 0..3 as numbers)
    int m_phase, m_net, m_run, m_quiet, m_blen;
    bit m_bv, m_bdir, m_eov, m_epre, m_elong;
    bit m_snk_prev, m_srcn_prev, m_in_pre;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic m_emit(input int len, input bit dir);
        m_bv   = 1'b1;
        m_blen = len;
        m_bdir = dir;
    endtask

    task automatic model_reset();
        m_phase = 0; m_net = 0; m_run = 0; m_quiet = 0; m_blen = 0;
        m_bv = 0; m_bdir = 0; m_eov = 0; m_epre = 0; m_elong = 0;
        m_snk_prev = 0; m_srcn_prev = 0; m_in_pre = 0;
    endtask

    task automatic model_step();
        bit sp, rp, nov, npre, nlong;
        int want;
        sp = snk_i && !m_snk_prev;
        rp = !src_n_i && m_srcn_prev;
        m_bv = 0; nov = 0; npre = 0; nlong = 0;
        if (preChrg_i) begin
            if (m_phase >= 2) m_emit(m_run, m_phase == 3);
            if (!m_in_pre) m_net = 0;
            m_phase = 1; m_run = 0; m_quiet = 0;
            npre = sp || rp;
        end else if (m_phase == 1) begin
            m_phase = 0;
            npre = sp || rp;
        end else if (sp && rp) begin
            nov = 1;
        end else if (sp || rp) begin
            want  = rp ? 3 : 2;
            m_net = clamp(m_net + (rp ? 1 : -1), NET_LO, NET_HI);
            if (m_phase == want) begin
                m_run = clamp(m_run + 1, 0, RUN_HI);
                if (m_run == MAX_BURST + 1) nlong = 1;
            end else begin
                if (m_phase != 0) m_emit(m_run, m_phase == 3);
                m_phase = want;
                m_run   = 1;
            end
            m_quiet = 0;
        end else if (m_phase >= 2) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_emit(m_run, m_phase == 3);
                m_phase = 0; m_run = 0; m_quiet = 0;
            end
        end
        m_eov   = nov   || (m_eov   && !clear_err);
        m_epre  = npre  || (m_epre  && !clear_err);
        m_elong = nlong || (m_elong && !clear_err);
        m_snk_prev  = snk_i;
        m_srcn_prev = src_n_i;
        m_in_pre    = preChrg_i;
    endtask

    task automatic compare_all();
        chk("phase",         int'(phase),         m_phase);
        chk("net_charge",    int'(net_charge),    m_net);
        chk("burst_valid",   int'(burst_valid),   int'(m_bv));
        chk("burst_len",     int'(burst_len),     m_blen);
        chk("burst_dir",     int'(burst_dir),     int'(m_bdir));
        chk("err_overlap",   int'(err_overlap),   int'(m_eov));
        chk("err_precharge", int'(err_precharge), int'(m_epre));
        chk("err_long",      int'(err_long),      int'(m_elong));
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then compare
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int found;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        step();
        // Reset values pinned by hand
        chk("rst_phase", int'(phase), 0);
        chk("rst_net", int'(net_charge), 0);
        chk("rst_len", int'(burst_len), 0);

        // 1: precharge hold and release
        preChrg_i = 1'b1;
        repeat (12) step();
        chk("t1_prechg_phase", int'(phase), 1);
        preChrg_i = 1'b0;
        step();
        chk("t1_idle_phase", int'(phase), 0);
        chk("t1_net", int'(net_charge), 0);
        chk("t1_no_err", int'({err_overlap, err_precharge, err_long}), 0);

        // 2: four sink edges then four source edges
        for (int i = 0; i < 7; i++) begin
            snk_i = (i % 2 == 0);
            step();
        end
        chk("t2_net_sink", int'(net_charge), -4);
        for (int i = 0; i < 7; i++) begin
            src_n_i = (i % 2 == 1);
            step();
            if (i == 0) begin
                chk("t2_bv", int'(burst_valid), 1);
                chk("t2_len", int'(burst_len), 4);
                chk("t2_dir", int'(burst_dir), 0);
            end
        end
        chk("t2_net_zero", int'(net_charge), 0);
        src_n_i = 1'b1;
        snk_i   = 1'b0;
        step();

        // 3: five sink pulses then quiet until timeout
        for (int i = 0; i < 5; i++) begin
            snk_i = 1'b1;
            step();
            if (i < 4) begin
                snk_i = 1'b0;
                step();
            end
        end
        snk_i = 1'b0;
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (burst_valid && found == 0) begin
                found = k;
                chk("t3_len", int'(burst_len), 5);
                chk("t3_dir", int'(burst_dir), 0);
            end
        end
        chk("t3_timeout_cycle", found, TIMEOUT);
        chk("t3_idle", int'(phase), 0);

        // 4: long sink burst, clear, then report
        for (int i = 0; i < 17; i++) begin
            snk_i = 1'b1;
            step();
            if (i == 15) chk("t4_long_16", int'(err_long), 0);
            if (i == 16) chk("t4_long_17", int'(err_long), 1);
            snk_i = 1'b0;
            step();
        end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t4_cleared", int'(err_long), 0);
        src_n_i = 1'b0;
        step();
        chk("t4_bv", int'(burst_valid), 1);
        chk("t4_len", int'(burst_len), 17);
        src_n_i = 1'b1;
        step();
        preChrg_i = 1'b1;
        repeat (2) step();
        preChrg_i = 1'b0;
        step();

        // 5: overlap, overlap during clear, pulse during precharge
        snk_i = 1'b1; src_n_i = 1'b0;
        step();
        chk("t5_overlap", int'(err_overlap), 1);
        chk("t5_net_kept", int'(net_charge), 0);
        chk("t5_phase_kept", int'(phase), 0);
        snk_i = 1'b0; src_n_i = 1'b1;
        step();
        snk_i = 1'b1; src_n_i = 1'b0; clear_err = 1'b1;
        step();
        chk("t5_new_wins", int'(err_overlap), 1);
        snk_i = 1'b0; src_n_i = 1'b1; clear_err = 1'b0;
        step();
        preChrg_i = 1'b1;
        step();
        snk_i = 1'b1;
        step();
        chk("t5_precharge", int'(err_precharge), 1);
        chk("t5_net_pre", int'(net_charge), 0);
        preChrg_i = 1'b0; snk_i = 1'b0;
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t5_all_clear", int'({err_overlap, err_precharge, err_long}), 0);

        // 6: positive saturation then reset mid-burst
        for (int i = 0; i < 130; i++) begin
            src_n_i = 1'b0;
            step();
            src_n_i = 1'b1;
            step();
        end
        chk("t6_net_sat", int'(net_charge), NET_HI);
        chk("t6_phase", int'(phase), 3);
        src_n_i = 1'b0;
        step();
        reset = 1'b1;
        repeat (2) step();
        src_n_i = 1'b1;
        reset = 1'b0;
        step();
        chk("t6_rst_bv", int'(burst_valid), 0);
        chk("t6_rst_phase", int'(phase), 0);
        chk("t6_rst_net", int'(net_charge), 0);
        chk("t6_rst_len", int'(burst_len), 0);
        chk("t6_rst_errs", int'({err_overlap, err_precharge, err_long}), 0);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
